// File: rtl/pix_stream_gen.sv
// pix_stream_gen: image-sensor emulator driving FV/LV/pixel timing.
// Ports: clk, rst, start, pattern -> busy, done, pix_frameValid, pix_lineValid, pix_d.
module pix_stream_gen #(
  parameter int Width      = 12,
  parameter int Cols       = 8,
  parameter int Rows       = 4,
  parameter int HBlank     = 2,
  parameter int VBlankPre  = 3,
  parameter int VBlankPost = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       pattern,
  output logic             busy,
  output logic             done,
  output logic             pix_frameValid,
  output logic             pix_lineValid,
  output logic [Width-1:0] pix_d
);

  localparam int CW = (Cols > 1) ? $clog2(Cols) : 1;
  localparam int RW = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int NW = (Rows * Cols > 1) ? $clog2(Rows * Cols) : 1;
  localparam int BM0 = (VBlankPre > VBlankPost) ? VBlankPre : VBlankPost;
  localparam int BMAX = (BM0 > HBlank) ? BM0 : HBlank;
  localparam int BW = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] ColLast  = CW'(Cols - 1);
  localparam logic [RW-1:0] RowLast  = RW'(Rows - 1);
  localparam logic [BW-1:0] PreLast  = BW'(VBlankPre - 1);
  localparam logic [BW-1:0] HbLast   = BW'(HBlank - 1);
  localparam logic [BW-1:0] PostLast = BW'(VBlankPost - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VPRE,
    S_ACTIVE,
    S_HBLANK,
    S_VPOST
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [NW-1:0]     n_q, n_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [1:0]        pat_q, pat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fv_q, fv_d;
  logic              lv_q, lv_d;
  logic [Width-1:0]  pd_q, pd_d;

  // Pixel value for a given position; wide values keep their low bits.
  function automatic logic [Width-1:0] pix_val(
    input logic [1:0]    p,
    input logic [RW-1:0] r,
    input logic [CW-1:0] c,
    input logic [NW-1:0] n
  );
    logic [31:0] v;
    v = '0;
    unique case (p)
      2'd0:    v = 32'(n);
      2'd1:    v = 32'(c);
      2'd2:    v = 32'(r);
      default: v = (r[0] ^ c[0]) ? '1 : '0;
    endcase
    return v[Width-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fv_d    = fv_q;
    lv_d    = 1'b0;
    pd_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        fv_d   = 1'b0;
        if (start) begin
          state_d = S_VPRE;
          pat_d   = pattern;
          row_d   = '0;
          col_d   = '0;
          n_d     = '0;
          cnt_d   = '0;
          fv_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_VPRE: begin
        if (cnt_q == PreLast) begin
          state_d = S_ACTIVE;
          lv_d    = 1'b1;
          pd_d    = pix_val(pat_q, row_q, col_q, n_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        n_d = n_q + 1'b1;
        if (col_q != ColLast) begin
          col_d = col_q + 1'b1;
          lv_d  = 1'b1;
          pd_d  = pix_val(pat_q, row_q, col_d, n_d);
        end else begin
          col_d = '0;
          cnt_d = '0;
          if (row_q != RowLast) begin
            row_d   = row_q + 1'b1;
            state_d = S_HBLANK;
          end else begin
            state_d = S_VPOST;
          end
        end
      end
      S_HBLANK: begin
        if (cnt_q == HbLast) begin
          state_d = S_ACTIVE;
          lv_d    = 1'b1;
          pd_d    = pix_val(pat_q, row_q, col_q, n_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VPOST: begin
        if (cnt_q == PostLast) begin
          state_d = S_IDLE;
          fv_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        fv_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      pd_q    <= pd_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pix_frameValid = fv_q;
  assign pix_lineValid  = lv_q;
  assign pix_d          = pd_q;

endmodule

// File: tb/tb_pix_stream_gen.sv
// tb_pix_stream_gen: randomized frames checked cycle by cycle
// against a waveform model built from the frame timing rules.
module tb_pix_stream_gen;

  localparam int W     = 12;
  localparam int COLS  = 8;
  localparam int ROWS  = 4;
  localparam int HB    = 2;
  localparam int VPRE  = 3;
  localparam int VPOST = 3;
  localparam int MASK  = (1 << W) - 1;
  localparam int FVLEN = VPRE + ROWS * COLS + (ROWS - 1) * HB + VPOST;

  typedef struct {
    bit fv;
    bit lv;
    int d;
  } smp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   pattern = 2'd0;
  logic         busy;
  logic         done;
  logic         fv;
  logic         lv;
  logic [W-1:0] pd;

  int   n_chk = 0;
  int   n_pass = 0;
  smp_t exq[$];

  always #5 clk = ~clk;

  pix_stream_gen #(
    .Width(W), .Cols(COLS), .Rows(ROWS),
    .HBlank(HB), .VBlankPre(VPRE), .VBlankPost(VPOST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pattern(pattern),
    .busy(busy),
    .done(done),
    .pix_frameValid(fv),
    .pix_lineValid(lv),
    .pix_d(pd)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic idle_chk(input string tag);
    check({tag, "_fv"}, int'(fv), 0);
    check({tag, "_lv"}, int'(lv), 0);
    check({tag, "_d"}, int'(pd), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  function automatic int model_pix(int p, int r, int c, int n);
    case (p)
      0: return n & MASK;
      1: return c & MASK;
      2: return r & MASK;
      default: return ((r ^ c) & 1) ? MASK : 0;
    endcase
  endfunction

  // Expected per-cycle FV/LV/data from the cycle after the start edge.
  task automatic build(input int p);
    int n;
    exq.delete();
    n = 0;
    repeat (VPRE) exq.push_back('{1'b1, 1'b0, 0});
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        exq.push_back('{1'b1, 1'b1, model_pix(p, r, c, n)});
        n++;
      end
      if (r < ROWS - 1) repeat (HB) exq.push_back('{1'b1, 1'b0, 0});
    end
    repeat (VPOST) exq.push_back('{1'b1, 1'b0, 0});
  endtask

  task automatic frame(input int p, input int pulse_at,
                       input bit abort, input bit hold);
    int fvc;
    int ab;
    build(p);
    ab = abort ? VPRE + 2 * (COLS + HB) + 4 : -1;
    start = 1'b1;
    pattern = 2'(p);
    @(posedge clk);
    fvc = 0;
    for (int k = 0; k < exq.size(); k++) begin
      @(negedge clk);
      if (fv) fvc++;
      check("fv", int'(fv), int'(exq[k].fv));
      check("lv", int'(lv), int'(exq[k].lv));
      check("pix_d", int'(pd), exq[k].d);
      check("busy", int'(busy), 1);
      check("done", int'(done), 0);
      pattern = 2'($urandom_range(0, 3));
      start = hold || (k == pulse_at);
      if (k == ab) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        idle_chk("abort");
        return;
      end
    end
    check("fv_len", fvc, FVLEN);
    @(negedge clk);
    check("end_fv", int'(fv), 0);
    check("end_lv", int'(lv), 0);
    check("end_d", int'(pd), 0);
    check("end_busy", int'(busy), 0);
    check("end_done", int'(done), 1);
    start = hold;
    if (!hold) begin
      @(negedge clk);
      idle_chk("post");
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      idle_chk("rst_idle");
    end
    frame(0, -1, 1'b0, 1'b0);
    frame(3, -1, 1'b0, 1'b0);
    frame(0, 10, 1'b0, 1'b0);
    frame(int'($urandom_range(0, 3)), -1, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      idle_chk("after_abort");
    end
    frame(0, -1, 1'b0, 1'b0);
    frame(int'($urandom_range(0, 3)), -1, 1'b0, 1'b1);
    frame(int'($urandom_range(0, 3)), -1, 1'b0, 1'b1);
    frame(int'($urandom_range(0, 3)), -1, 1'b0, 1'b0);
    repeat (8) begin
      frame(int'($urandom_range(0, 3)),
            int'($urandom_range(0, FVLEN - 1)), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        idle_chk("gap");
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
